bus_split_seq: RTL
==================

# bus_split_seq

Parametrised, sequential successor to the fixed 16-bit bit splitter. It accepts one IN_W-bit word per handshake and emits it as IN_W/OUT_W consecutive OUT_W-bit slices on a valid/ready stream, in LSB-first or MSB-first order. Slices carry position tags. Back-to-back words stream with no bubble. It sits between wide register/bus sources and narrow downstream consumers (serial links, narrow latches) in the converted netlist.

## Interface
- IN_W, default 16: input word width; must be an integer multiple of OUT_W.
- OUT_W, default 1: slice width. The default reproduces bit-by-bit splitting.
- MSB_FIRST, default 0: 0 emits slice 0 (bits OUT_W-1:0) first; 1 emits the top slice first.
- Derived: N = IN_W/OUT_W; IW = max(1, $clog2(N)).

Ports:
- CLK  in  1  sole clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- IN  in  IN_W  word to split.
- IN_VALID  in  1  IN holds a word.
- IN_READY  out  1  block will accept IN this cycle.
- OUT  out  OUT_W  current slice.
- OUT_VALID  out  1  OUT holds a slice.
- OUT_READY  in  1  consumer takes OUT this cycle.
- OUT_IDX  out  IW  bit-position index of the current slice within the word (0 = bits OUT_W-1:0).
- OUT_FIRST  out  1  current slice is the first emitted for its word.
- OUT_LAST  out  1  current slice is the last emitted for its word.

## Operation
- **States:**
  - IDLE: no word held.
  - EMIT: word held; counter CNT (0..N-1) counts emitted slices.
- **Transfers:** an in-transfer is IN_VALID & IN_READY; an out-transfer is OUT_VALID & OUT_READY.
- **Handshake outputs:**
  - IN_READY = (state==IDLE) | (state==EMIT & OUT_LAST & OUT_READY).
  - OUT_VALID = (state==EMIT).
- **IDLE + in-transfer:** latch IN into HOLD, CNT<=0, go to EMIT.
- **EMIT + out-transfer, not last:** CNT<=CNT+1.
- **EMIT + out-transfer on the last slice:**
  - With a simultaneous in-transfer: reload HOLD, CNT<=0, stay in EMIT (no bubble).
  - Otherwise: go to IDLE.
- **Slice selection:**
  - OUT_IDX = MSB_FIRST ? N-1-CNT : CNT.
  - OUT = HOLD[OUT_IDX*OUT_W +: OUT_W].
  - OUT_FIRST = (CNT==0); OUT_LAST = (CNT==N-1).
- **Stall and stability:** if OUT_READY is low, OUT, OUT_IDX, OUT_FIRST and OUT_LAST hold stable. OUT_VALID never deasserts before its out-transfer.
- **IN sampling:** IN is sampled only on an in-transfer. IN_VALID without IN_READY has no effect; the producer must hold IN.
- **N==1:** every slice has FIRST=LAST=1 and OUT_IDX=0. The block degenerates to a one-deep registered pipeline stage with full throughput.
- **IN_W not a multiple of OUT_W:** elaboration error via a generate-time check.

## Timing
- **Reset values** (RESET high at an edge): state=IDLE, CNT=0, HOLD=0. Outputs: OUT_VALID=0, IN_READY=1, OUT=0, OUT_IDX=0 (MSB_FIRST=0) or N-1 (MSB_FIRST=1), OUT_FIRST=1, OUT_LAST=(N==1).
- **RESET priority:** RESET overrides any simultaneous transfer. A partially emitted word is discarded, and no further slices of it appear after the reset edge.
- **Latency:** in-transfer at edge k gives the first slice valid from edge k to k+1 (one cycle).
- **Throughput:** one slice per cycle with OUT_READY held high. A word occupies exactly N cycles; continuous input gives 100% output utilisation.
- **Combinational paths:** IN_READY depends combinationally on OUT_READY; this is the only such path. OUT, OUT_VALID and the tags are register-derived.

## Structure
- A shared package `bus_split_pkg` holds:
  - state enum {IDLE, EMIT};
  - function idx_w(N), giving max(1,$clog2(N)), reused by later join/serialiser blocks.
- One natural sub-module, `slice_mux`: a parametrised HOLD-to-OUT selector taking OUT_IDX. The same selector serves the planned companion `bus_join_seq`.
- Everything else (FSM, counter, HOLD) lives in the top level, roughly 150 lines of RTL.

## Test plan
- **Basic LSB-first:** IN_W=16, OUT_W=4, IN=16'hA5C3, OUT_READY=1 → OUT 3,C,5,A on four consecutive cycles; OUT_IDX 0,1,2,3; FIRST on the 1st slice, LAST on the 4th.
- **MSB-first:** MSB_FIRST=1, same word → OUT A,5,C,3; OUT_IDX 3,2,1,0.
- **Back-to-back:** words 16'h1234 then 16'h5678 with IN_VALID held → 8 consecutive valid cycles, OUT 4,3,2,1,8,7,6,5. IN_READY is high only in the cycle of each last slice (and in IDLE).
- **Backpressure:** OUT_READY low for 3 cycles during slice 2 of 16'hBEEF → OUT stays E (OUT_IDX 1) and stable; the sequence resumes with E,B; word total is 4 transfers.
- **Reset mid-word:** RESET during slice 1 → next cycle OUT_VALID=0 and IN_READY=1. A new word 16'h0F0F starts cleanly at OUT_IDX 0 with FIRST=1.
- **Degenerate and default sizes:**
  - OUT_W=1 (defaults): 16'h8001 → bits 1,0…0,1 over 16 cycles.
  - OUT_W=IN_W: each word is one cycle, FIRST=LAST=1, full throughput.

Source files
------------

// File: rtl/bus_split_pkg.sv
// Shared types and helpers for the bus split/join family.
package bus_split_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Width of a slice index for an n-slice word; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_split_seq_slice_mux.sv
// Selects one OUT_W-bit slice out of a held IN_W-bit word by slice index.
module slice_mux #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 1,
  parameter int IW    = 4
) (
  input  logic [IN_W-1:0]  i_hold,
  input  logic [IW-1:0]    i_idx,
  output logic [OUT_W-1:0] o_slice
);

  int w_base;

  // Bit offset of the selected slice, then an indexed part-select.
  always_comb begin
    w_base  = int'(i_idx) * OUT_W;
    o_slice = i_hold[w_base +: OUT_W];
  end

endmodule

// File: rtl/bus_split_seq.sv
// Word-to-slice stream splitter: one IN_W word in, IN_W/OUT_W slices out,
// LSB-first or MSB-first, with position tags and no bubble between words.
import bus_split_pkg::*;

module bus_split_seq #(
  parameter  int IN_W      = 16,
  parameter  int OUT_W     = 1,
  parameter  bit MSB_FIRST = 1'b0,
  localparam int N         = IN_W / OUT_W,
  localparam int IW        = idx_w(N)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [IN_W-1:0]  IN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [OUT_W-1:0] OUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [IW-1:0]    OUT_IDX,
  output logic             OUT_FIRST,
  output logic             OUT_LAST
);

  localparam logic [IW-1:0] LAST_CNT = IW'(N - 1);

  // Refuse to elaborate when the word does not divide into whole slices.
  generate
    if ((IN_W % OUT_W) != 0) begin : g_bad_width
      $error("bus_split_seq: IN_W must be a multiple of OUT_W");
    end
  endgenerate

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IN_W-1:0] r_hold;
  logic [IW-1:0]   r_cnt;
  logic            w_load;
  logic            w_adv;
  logic            w_last;
  logic [IW-1:0]   w_idx;

  // Tags are pure functions of the slice counter, so they hold during stalls.
  always_comb begin
    w_last    = (r_cnt == LAST_CNT);
    w_idx     = MSB_FIRST ? (LAST_CNT - r_cnt) : r_cnt;
    OUT_IDX   = w_idx;
    OUT_FIRST = (r_cnt == '0);
    OUT_LAST  = w_last;
    OUT_VALID = (r_state == EMIT);
  end

  // State register; reset wins over any transfer in the same cycle.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, handshake and load/advance strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    IN_READY    = 1'b0;
    case (r_state)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          w_load      = 1'b1;
          w_state_nxt = EMIT;
        end
      end
      EMIT: begin
        // Accept the next word while the last slice leaves: no bubble.
        IN_READY = w_last & OUT_READY;
        if (OUT_READY) begin
          if (!w_last)       w_adv       = 1'b1;
          else if (IN_VALID) w_load      = 1'b1;
          else               w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Held word and emitted-slice counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_hold <= '0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_hold <= IN;
      r_cnt  <= '0;
    end else if (w_adv) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  slice_mux #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .IW    (IW)
  ) u_slice_mux (
    .i_hold  (r_hold),
    .i_idx   (w_idx),
    .o_slice (OUT)
  );

endmodule
